// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the register-bank write arbiter:
//   DATA_W / REG_ADDR_W / NUM_REGS / ZERO_REG  - bank geometry
//   wb_req_t   - one writeback request {addr, data}
//   reg_mask_t - one bit per register (write enables, scoreboard)
//   rr_ptr_e   - which requester the round-robin pointer favours
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     reg_data_t;
   typedef logic [NUM_REGS-1:0]   reg_mask_t;

   // Hardwired-zero register: writes to it are dropped, it is never busy.
   localparam reg_addr_t ZERO_REG = 5'd31;

   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } wb_req_t;

   typedef enum logic {
      PTR_A = 1'b0,
      PTR_B = 1'b1
   } rr_ptr_e;

   function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
      reg_onehot = reg_mask_t'(1) << addr;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles every non-clock/reset signal of the write arbiter.
//   decode side   : reserve_valid, reserve_addr (in), busy (out)
//   requester A   : a_valid, a_addr, a_data (in), a_ready (out)  - ALU writeback
//   requester B   : b_valid, b_addr, b_data (in), b_ready (out)  - load return
//   bank side     : wr_en, wr_data (out, registered)
//   status        : last_grant (out)
//   REGFILE_WB_BYPASS_EN adds byp_valid, byp_addr, byp_data (out).
// modport slave is the arbiter, modport master is the surrounding pipeline.
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if;
   import regfile_pkg::*;

   logic      reserve_valid;
   reg_addr_t reserve_addr;

   logic      a_valid;
   logic      a_ready;
   reg_addr_t a_addr;
   reg_data_t a_data;

   logic      b_valid;
   logic      b_ready;
   reg_addr_t b_addr;
   reg_data_t b_data;

   reg_mask_t wr_en;
   reg_data_t wr_data;
   reg_mask_t busy;
   logic      last_grant;

`ifdef REGFILE_WB_BYPASS_EN
   logic      byp_valid;
   reg_addr_t byp_addr;
   reg_data_t byp_data;
`endif

   modport slave (
`ifdef REGFILE_WB_BYPASS_EN
      output byp_valid, byp_addr, byp_data,
`endif
      input  reserve_valid, reserve_addr,
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready,
      output wr_en, wr_data, busy, last_grant
   );

   modport master (
`ifdef REGFILE_WB_BYPASS_EN
      input  byp_valid, byp_addr, byp_data,
`endif
      output reserve_valid, reserve_addr,
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready,
      input  wr_en, wr_data, busy, last_grant
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant with a same-address override.
//   clk, reset       : clock, asynchronous active-low reset
//   i_a_valid        : requester A wants the write port
//   i_b_valid        : requester B wants the write port
//   i_same_addr      : both target the same register -> B (older load) wins
//   o_grant_a/_b     : combinational grants, at most one high, low in reset
//   o_last_grant     : winner of the most recent different-address contention
// The pointer only moves on a different-address contention; single requests
// and same-address collisions leave it alone.
// -----------------------------------------------------------------------------
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_a_valid,
   input  logic i_b_valid,
   input  logic i_same_addr,
   output logic o_grant_a,
   output logic o_grant_b,
   output logic o_last_grant
);

   rr_ptr_e r_ptr;
   rr_ptr_e w_ptr_next;
   logic    r_last_grant;
   logic    w_last_grant_next;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr        <= PTR_A;
         r_last_grant <= 1'b0;
      end else begin
         r_ptr        <= w_ptr_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the if/else tree can leave one unassigned and infer a latch.
   always_comb begin
      w_ptr_next        = r_ptr;
      w_last_grant_next = r_last_grant;
      o_grant_a         = 1'b0;
      o_grant_b         = 1'b0;
      // Grants are qualified with reset so no handshake completes while the
      // block is held in reset.
      if (reset) begin
         if (i_a_valid && i_b_valid) begin
            if (i_same_addr) begin
               o_grant_b = 1'b1;
            end else if (r_ptr == PTR_A) begin
               o_grant_a         = 1'b1;
               w_ptr_next        = PTR_B;
               w_last_grant_next = 1'b0;
            end else begin
               o_grant_b         = 1'b1;
               w_ptr_next        = PTR_A;
               w_last_grant_next = 1'b1;
            end
         end else if (i_a_valid) begin
            o_grant_a = 1'b1;
         end else if (i_b_valid) begin
            o_grant_b = 1'b1;
         end
      end
   end

   assign o_last_grant = r_last_grant;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single write port of the 32x64 register bank between ALU
// writeback (A) and load return (B), and keeps the RAW busy scoreboard.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : regfile_write_arbiter_if.slave (requests, bank write, scoreboard)
// An accepted request in cycle N appears on wr_en/wr_data in N+1 and the busy
// bit of its register clears at the end of N+1, when the bank captures it.
// Optional feature macro: REGFILE_WB_BYPASS_EN adds a combinational forward
// (byp_valid/byp_addr/byp_data) of the transfer accepted in the current cycle.
// -----------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);

   wb_req_t   w_a_req;
   wb_req_t   w_b_req;
   wb_req_t   w_win_req;
   logic      w_grant_a;
   logic      w_grant_b;
   logic      w_accept;
   logic      w_commit;
   reg_mask_t w_set_mask;

   reg_mask_t r_wr_en;
   reg_data_t r_wr_data;
   reg_mask_t r_busy;

   assign w_a_req = '{addr: bus.a_addr, data: bus.a_data};
   assign w_b_req = '{addr: bus.b_addr, data: bus.b_data};

   rr_arbiter2 u_rr_arbiter2 (
      .clk          (clk),
      .reset        (reset),
      .i_a_valid    (bus.a_valid),
      .i_b_valid    (bus.b_valid),
      .i_same_addr  (bus.a_addr == bus.b_addr),
      .o_grant_a    (w_grant_a),
      .o_grant_b    (w_grant_b),
      .o_last_grant (bus.last_grant)
   );

   assign w_win_req = w_grant_b ? w_b_req : w_a_req;
   assign w_accept  = w_grant_a | w_grant_b;
   // A zero-register write still handshakes but never reaches the bank.
   assign w_commit  = w_accept && (w_win_req.addr != ZERO_REG);

   assign w_set_mask = (bus.reserve_valid && (bus.reserve_addr != ZERO_REG))
                       ? reg_onehot(bus.reserve_addr) : '0;

   // NOTE: wr_data is a single output register, not a storage array, so it is
   // reset to give the bank port a defined value; the bank itself is not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_en   <= '0;
         r_wr_data <= '0;
         r_busy    <= '0;
      end else begin
         r_wr_en <= w_commit ? reg_onehot(w_win_req.addr) : '0;
         if (w_accept) begin
            r_wr_data <= w_win_req.data;
         end
         // Clear by the write the bank captures at this edge, then set by a
         // new reservation so a same-edge reserve wins.
         r_busy <= (r_busy & ~r_wr_en) | w_set_mask;
      end
   end

   assign bus.a_ready = w_grant_a;
   assign bus.b_ready = w_grant_b;
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_data = r_wr_data;
   assign bus.busy    = r_busy;

`ifdef REGFILE_WB_BYPASS_EN
   // Grants are already low during reset, so w_commit covers that case too.
   assign bus.byp_valid = w_commit;
   assign bus.byp_addr  = w_win_req.addr;
   assign bus.byp_data  = w_win_req.data;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed scenarios followed by a randomized run checked against a
// behavioural model of the arbitration and scoreboard rules.
// Define REGFILE_WB_BYPASS_EN to also exercise the forwarding outputs.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Inputs are driven at posedge+1; combinational outputs are checked at
   // posedge+2 and registered outputs at posedge+1.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.a_valid       = 1'b0;
      bus.b_valid       = 1'b0;
      bus.reserve_valid = 1'b0;
   endtask

   task automatic drive_a(input logic v, input reg_addr_t addr, input reg_data_t data);
      bus.a_valid = v;
      bus.a_addr  = addr;
      bus.a_data  = data;
   endtask

   task automatic drive_b(input logic v, input reg_addr_t addr, input reg_data_t data);
      bus.b_valid = v;
      bus.b_addr  = addr;
      bus.b_data  = data;
   endtask

   task automatic reserve(input logic v, input reg_addr_t addr);
      bus.reserve_valid = v;
      bus.reserve_addr  = addr;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      drive_b(1'b0, 5'd0, '0);
      reserve(1'b0, 5'd0);
      drive_a(1'b1, 5'd1, 64'h1);
      #2;
      n_checks++; if (bus.a_ready !== 1'b0) $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle();
      reset = 1'b1;
      step();
      n_checks++; if (bus.wr_en !== 32'h0) $display("FAIL reset_wr_en: got %h want 0", bus.wr_en); else n_pass++;
      n_checks++; if (bus.busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.last_grant !== 1'b0) $display("FAIL reset_last_grant: got %b want 0", bus.last_grant); else n_pass++;
      drive_a(1'b1, 5'd5, 64'hAA);
      #1;
      n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL first_a_ready: got %b want 1", bus.a_ready); else n_pass++;
      step();
      idle();
      n_checks++; if (bus.wr_en !== 32'h20) $display("FAIL first_wr_en: got %h want 20", bus.wr_en); else n_pass++;
      n_checks++; if (bus.wr_data !== 64'hAA) $display("FAIL first_wr_data: got %h want aa", bus.wr_data); else n_pass++;
      step();
   endtask

   task automatic test_contention();
      logic exp_a;
      for (int i = 0; i < 4; i++) begin
         exp_a = (i % 2 == 0);
         drive_a(1'b1, 5'd3, 64'hA000 + 64'(i));
         drive_b(1'b1, 5'd7, 64'hB000 + 64'(i));
         #1;
         n_checks++; if (bus.a_ready !== exp_a || bus.b_ready !== !exp_a)
            $display("FAIL contend_grant%0d: got a=%b b=%b want a=%b", i, bus.a_ready, bus.b_ready, exp_a); else n_pass++;
         step();
         n_checks++; if (bus.wr_en !== (exp_a ? 32'h8 : 32'h80))
            $display("FAIL contend_wr_en%0d: got %h want %h", i, bus.wr_en, exp_a ? 32'h8 : 32'h80); else n_pass++;
         n_checks++; if (bus.wr_data !== (exp_a ? 64'hA000 : 64'hB000) + 64'(i))
            $display("FAIL contend_wr_data%0d: got %h", i, bus.wr_data); else n_pass++;
         n_checks++; if (bus.last_grant !== !exp_a)
            $display("FAIL contend_last_grant%0d: got %b want %b", i, bus.last_grant, !exp_a); else n_pass++;
      end
      idle();
      step();
   endtask

   task automatic test_same_addr();
      // Pointer favours A here and last_grant is 1 after the contention test.
      drive_a(1'b1, 5'd9, 64'h111);
      drive_b(1'b1, 5'd9, 64'h222);
      #1;
      n_checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0)
         $display("FAIL same_addr_grant: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready); else n_pass++;
      step();
      drive_b(1'b0, 5'd9, 64'h222);
      #1;
      n_checks++; if (bus.last_grant !== 1'b1) $display("FAIL same_addr_last_grant: got %b want 1", bus.last_grant); else n_pass++;
      n_checks++; if (bus.wr_data !== 64'h222) $display("FAIL same_addr_wr_data_b: got %h want 222", bus.wr_data); else n_pass++;
      n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL same_addr_a_next: got %b want 1", bus.a_ready); else n_pass++;
      step();
      idle();
      n_checks++; if (bus.wr_en !== 32'h200) $display("FAIL same_addr_wr_en_a: got %h want 200", bus.wr_en); else n_pass++;
      n_checks++; if (bus.wr_data !== 64'h111) $display("FAIL same_addr_wr_data_a: got %h want 111", bus.wr_data); else n_pass++;
      step();
   endtask

   task automatic test_scoreboard();
      for (int pass = 0; pass < 2; pass++) begin
         reserve(1'b1, 5'd12);                                  // cycle 0
         step();                                                // cycle 1
         reserve(1'b0, 5'd12);
         n_checks++; if (bus.busy[12] !== 1'b1) $display("FAIL sb%0d_set: got %b want 1", pass, bus.busy[12]); else n_pass++;
         step();                                                // cycle 2
         step();                                                // cycle 3
         drive_a(1'b1, 5'd12, 64'hC0C0 + 64'(pass));
         #1;
         n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL sb%0d_a_ready: got %b want 1", pass, bus.a_ready); else n_pass++;
         step();                                                // cycle 4
         idle();
         if (pass == 1) reserve(1'b1, 5'd12);
         n_checks++; if (bus.wr_en !== 32'h1000) $display("FAIL sb%0d_wr_en: got %h want 1000", pass, bus.wr_en); else n_pass++;
         n_checks++; if (bus.busy[12] !== 1'b1) $display("FAIL sb%0d_busy_c4: got %b want 1", pass, bus.busy[12]); else n_pass++;
         step();                                                // cycle 5
         reserve(1'b0, 5'd12);
         n_checks++; if (bus.busy[12] !== (pass == 1)) $display("FAIL sb%0d_busy_c5: got %b want %b", pass, bus.busy[12], pass == 1); else n_pass++;
      end
      step();
   endtask

   task automatic test_zero_reg();
      reserve(1'b1, ZERO_REG);
      drive_a(1'b1, ZERO_REG, 64'hDEAD);
      #1;
      n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL zero_a_ready: got %b want 1", bus.a_ready); else n_pass++;
      step();
      idle();
      n_checks++; if (bus.wr_en !== 32'h0) $display("FAIL zero_wr_en: got %h want 0", bus.wr_en); else n_pass++;
      n_checks++; if (bus.busy[31] !== 1'b0) $display("FAIL zero_busy: got %b want 0", bus.busy[31]); else n_pass++;
      step();
      n_checks++; if (bus.busy[31] !== 1'b0) $display("FAIL zero_busy_late: got %b want 0", bus.busy[31]); else n_pass++;
   endtask

`ifdef REGFILE_WB_BYPASS_EN
   task automatic test_bypass();
      drive_a(1'b1, 5'd4, 64'h1234);
      #1;
      n_checks++; if (bus.byp_valid !== 1'b1) $display("FAIL byp_valid: got %b want 1", bus.byp_valid); else n_pass++;
      n_checks++; if (bus.byp_addr !== 5'd4) $display("FAIL byp_addr: got %0d want 4", bus.byp_addr); else n_pass++;
      n_checks++; if (bus.byp_data !== 64'h1234) $display("FAIL byp_data: got %h want 1234", bus.byp_data); else n_pass++;
      step();
      drive_a(1'b0, 5'd4, 64'h1234);
      drive_b(1'b1, ZERO_REG, 64'h55);
      #1;
      n_checks++; if (bus.byp_valid !== 1'b0) $display("FAIL byp_zero: got %b want 0", bus.byp_valid); else n_pass++;
      step();
      idle();
      step();
   endtask
`endif

   task automatic test_async_reset();
      reserve(1'b1, 5'd20);
      drive_a(1'b1, 5'd6, 64'h6666);
      step();
      idle();
      n_checks++; if (bus.wr_en !== 32'h40) $display("FAIL arst_pending: got %h want 40", bus.wr_en); else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (bus.wr_en !== 32'h0) $display("FAIL arst_wr_en: got %h want 0", bus.wr_en); else n_pass++;
      n_checks++; if (bus.busy !== 32'h0) $display("FAIL arst_busy: got %h want 0", bus.busy); else n_pass++;
      drive_a(1'b1, 5'd2, 64'h2);
      #1;
      n_checks++; if (bus.a_ready !== 1'b0) $display("FAIL arst_a_ready: got %b want 0", bus.a_ready); else n_pass++;
`ifdef REGFILE_WB_BYPASS_EN
      n_checks++; if (bus.byp_valid !== 1'b0) $display("FAIL arst_byp_valid: got %b want 0", bus.byp_valid); else n_pass++;
`endif
      idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      n_checks++; if (bus.wr_en !== 32'h0) $display("FAIL arst_no_commit: got %h want 0", bus.wr_en); else n_pass++;
      n_checks++; if (bus.last_grant !== 1'b0) $display("FAIL arst_last_grant: got %b want 0", bus.last_grant); else n_pass++;
      step();
      n_checks++; if (bus.busy !== 32'h0 || bus.wr_en !== 32'h0)
         $display("FAIL arst_quiet: got busy=%h wr_en=%h want 0", bus.busy, bus.wr_en); else n_pass++;
   endtask

   function automatic reg_addr_t pick_addr();
      if ($urandom_range(0, 7) == 0) return ZERO_REG;
      return 5'($urandom_range(0, 15));
   endfunction

   // Model: requests held until granted, a "favours B" flag, the winner of
   // the last different-address contention, one bit per register for busy,
   // and the write sitting on the bank port this cycle.
   task automatic test_random();
      logic      a_pend = 1'b0, b_pend = 1'b0;
      reg_addr_t a_addr = '0, b_addr = '0, r_addr;
      reg_data_t a_data = '0, b_data = '0;
      logic      r_v;
      logic      m_fav_b = 1'b0, m_last = 1'b0;
      bit        m_busy[NUM_REGS];
      logic      m_wr_valid = 1'b0;
      int        m_wr_reg = 0;
      reg_data_t m_data = '0;
      logic      m_known = 1'b1;
      logic      exp_ga, exp_gb;
      reg_addr_t w_addr;
      logic [31:0] exp_mask;
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!a_pend && $urandom_range(0, 2) != 0) begin
            a_pend = 1'b1; a_addr = pick_addr(); a_data = {$urandom, $urandom};
         end
         if (!b_pend && $urandom_range(0, 2) != 0) begin
            b_pend = 1'b1;
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : pick_addr();
            b_data = {$urandom, $urandom};
         end
         r_v    = ($urandom_range(0, 3) == 0);
         r_addr = pick_addr();
         drive_a(a_pend, a_addr, a_data);
         drive_b(b_pend, b_addr, b_data);
         reserve(r_v, r_addr);
         #1;

         exp_ga = 1'b0; exp_gb = 1'b0;
         if (a_pend && b_pend) begin
            if (a_addr == b_addr) exp_gb = 1'b1;
            else if (m_fav_b)     exp_gb = 1'b1;
            else                  exp_ga = 1'b1;
         end else if (a_pend) exp_ga = 1'b1;
         else if (b_pend)     exp_gb = 1'b1;

         n_checks++; if (bus.a_ready !== exp_ga || bus.b_ready !== exp_gb)
            $display("FAIL rnd_grant c%0d: got a=%b b=%b want a=%b b=%b", cyc, bus.a_ready, bus.b_ready, exp_ga, exp_gb); else n_pass++;
         w_addr = exp_gb ? b_addr : a_addr;
`ifdef REGFILE_WB_BYPASS_EN
         n_checks++; if (bus.byp_valid !== ((exp_ga || exp_gb) && w_addr != ZERO_REG))
            $display("FAIL rnd_byp c%0d: got %b", cyc, bus.byp_valid); else n_pass++;
`endif

         if (a_pend && b_pend && a_addr != b_addr) begin
            m_last  = exp_gb;
            m_fav_b = exp_ga;
         end
         // Busy: the write on the bank port clears its bit, a reserve sets.
         if (m_wr_valid) m_busy[m_wr_reg] = 1'b0;
         if (r_v && r_addr != ZERO_REG) m_busy[r_addr] = 1'b1;
         m_wr_valid = 1'b0;
         if (exp_ga || exp_gb) begin
            m_data = exp_gb ? b_data : a_data;
            if (w_addr != ZERO_REG) begin
               m_wr_valid = 1'b1; m_wr_reg = int'(w_addr); m_known = 1'b1;
            end else begin
               m_known = 1'b0;
            end
         end
         if (exp_ga) a_pend = 1'b0;
         if (exp_gb) b_pend = 1'b0;

         step();
         exp_mask = '0;
         if (m_wr_valid) exp_mask[m_wr_reg] = 1'b1;
         n_checks++; if (bus.wr_en !== exp_mask)
            $display("FAIL rnd_wr_en c%0d: got %h want %h", cyc, bus.wr_en, exp_mask); else n_pass++;
         if (m_known) begin
            n_checks++; if (bus.wr_data !== m_data)
               $display("FAIL rnd_wr_data c%0d: got %h want %h", cyc, bus.wr_data, m_data); else n_pass++;
         end
         exp_mask = '0;
         for (int r = 0; r < NUM_REGS; r++) exp_mask[r] = m_busy[r];
         n_checks++; if (bus.busy !== exp_mask)
            $display("FAIL rnd_busy c%0d: got %h want %h", cyc, bus.busy, exp_mask); else n_pass++;
         n_checks++; if (bus.last_grant !== m_last)
            $display("FAIL rnd_last_grant c%0d: got %b want %b", cyc, bus.last_grant, m_last); else n_pass++;
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_same_addr();
      test_scoreboard();
      test_zero_reg();
`ifdef REGFILE_WB_BYPASS_EN
      test_bypass();
`endif
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×64-bit register bank between two writeback sources: ALU writeback (requester A) and load return (requester B). Each source uses a valid/ready handshake. The block arbitrates round-robin, registers the winning write into a one-hot write-enable plus data for the bank, and keeps a 32-bit busy scoreboard that decode consults for RAW hazards. It sits between the pipeline's writeback stage and the register bank.

## Interface
- DATA_W, 64, write data width
- NUM_REGS, 32, register count; addresses are 5 bits
- ZERO_REG, 31, hardwired-zero register; writes to it are discarded

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- reserve_valid  in  1  decode marks a destination register as pending
- reserve_addr  in  5  register being reserved
- a_valid  in  1  ALU writeback request
- a_ready  out  1  ALU request accepted this cycle
- a_addr  in  5  ALU destination register
- a_data  in  DATA_W  ALU result
- b_valid  in  1  load-return request
- b_ready  out  1  load request accepted this cycle
- b_addr  in  5  load destination register
- b_data  in  DATA_W  load data
- wr_en  out  NUM_REGS  one-hot write enable to the bank (registered)
- wr_data  out  DATA_W  write data to the bank (registered)
- busy  out  NUM_REGS  scoreboard; bit i high means register i has a write in flight
- last_grant  out  1  0 = A, 1 = B; requester that won the most recent contended cycle

## Operation
- A transfer occurs when valid and ready are both high in the same cycle.
- A requester's valid, addr and data must stay stable until it is accepted.
- a_ready and b_ready are combinational functions of a_valid, b_valid, the addresses and the priority pointer.
- At most one ready is high per cycle.
- Single requester valid: it is granted immediately. The pointer does not change.
- Both valid, different addresses: grant the requester the pointer favours, then point the pointer at the other requester.
- Both valid, same address: grant B, because the load is the older instruction. The pointer does not change.
- Accepted write with addr == ZERO_REG:
  - the handshake still completes;
  - wr_en stays all zeros next cycle;
  - busy is not touched.
- Accepted write to register r:
  - next cycle wr_en = 1<<r and wr_data = the accepted data;
  - if nothing is accepted, wr_en = 0 and wr_data holds its previous value.
- Scoreboard:
  - reserve_valid sets busy[reserve_addr] at the next edge;
  - a commit clears busy[r] at the edge where the bank captures the write, i.e. the edge ending the cycle in which wr_en[r] is high;
  - set and clear of the same bit at the same edge: the set wins;
  - reserve of ZERO_REG is ignored;
  - busy[ZERO_REG] is always 0.
- Reset (asynchronous, active-low):
  - wr_en = 0, wr_data = 0, busy = 0;
  - pointer favours A, last_grant = 0;
  - a_ready and b_ready are low while reset is asserted.
  - Reset asserted mid-operation drops any registered write that has not yet committed.

## Timing
- Accept in cycle N, then wr_en/wr_data valid in cycle N+1.
- The bank captures the write at the end of N+1; read ports see it from N+2.
- busy[r] falls at the end of N+1, so it goes low at the same time the new value becomes readable.
- Throughput: one write per cycle.
- Starvation bound: a contended requester is granted within 2 cycles, except when it loses repeated same-address collisions, which callers must not generate.
- reserve_valid in cycle N makes busy high from N+1.

## Configuration
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds the outputs byp_valid (1), byp_addr (5) and byp_data (DATA_W).
  - They are combinational copies of the transfer accepted in cycle N, visible in N.
  - This lets decode forward a result two cycles before the bank can supply it.
  - byp_valid is 0 for ZERO_REG writes and during reset.
- Undefined: these ports do not exist, and there is no forwarding path.

## Structure
- Package regfile_pkg holds:
  - constants DATA_W = 64, REG_ADDR_W = 5, NUM_REGS = 32, ZERO_REG = 31;
  - typedef wb_req_t, a struct of {addr, data};
  - typedef reg_mask_t, which is logic [NUM_REGS-1:0].
- Sub-module rr_arbiter2 holds the two-way round-robin grant and the pointer flop.
  - It takes a same-address override input that forces the grant to B.
- The top level holds the output registers and the scoreboard.

## Test plan
- Reset check: release reset, then expect wr_en = 0, busy = 0, last_grant = 0. Set a_valid with addr 5 and data 0xAA. Expect a_ready = 1 in the same cycle, then wr_en = 0x20 and wr_data = 0xAA next cycle.
- Contention: A (addr 3) and B (addr 7) both held valid for 4 cycles. Expect grants A, B, A, B and commits to regs 3, 7, 3, 7.
- Same-address collision: A and B both target addr 9. Expect b_ready = 1 and a_ready = 0 in the same cycle; last_grant unchanged; A is granted in the next cycle.
- Scoreboard: reserve 12 in cycle 0, so busy[12] = 1 from cycle 1. A writes 12 in cycle 3, wr_en[12] in cycle 4, busy[12] = 0 from cycle 5. Repeat with a reserve of 12 in cycle 4: busy[12] stays 1.
- Zero register: reserve 31 and A write to 31. Expect a_ready = 1, wr_en = 0 next cycle, busy[31] = 0 throughout.
- Async reset with a write pending in the output register: pull reset low between edges. Expect wr_en = 0 and busy = 0 immediately, and no commit after release.
- With REGFILE_WB_BYPASS_EN defined: A writes 4 with 0x1234 and is accepted in cycle N. Expect byp_valid = 1, byp_addr = 4, byp_data = 0x1234 in cycle N.
